// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand-fetch stage: sizes, ALU opcodes, zero register.
package operand_fetch_pkg;

  localparam int DW    = 32;
  localparam int NREGS = 16;
  localparam int AW    = 4;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLA  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/operand_fetch_regfile_2r1w.sv
// Register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, whole array cleared by rst_n.
module regfile_2r1w #(
  parameter int DW    = operand_fetch_pkg::DW,
  parameter int NREGS = operand_fetch_pkg::NREGS,
  parameter int AW    = operand_fetch_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  // Flattened view of every register, r0 tied to zero.
  logic [DW-1:0] words [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_word
      if (gi == 0) begin : g_zero
        assign words[gi] = '0;
      end else begin : g_store
        logic [DW-1:0] word_reg;
        // Each register loads only when addressed by the write port.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            word_reg <= '0;
          end else if (we && waddr == AW'(gi)) begin
            word_reg <= wdata;
          end
        end
        assign words[gi] = word_reg;
      end
    end
  endgenerate

  assign rdata_a = words[raddr_a];
  assign rdata_b = words[raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register read with write-back bypass, busy-bit
// scoreboard for RAW/WAW stalls, single-entry valid/ready output register.
module operand_fetch #(
  parameter int DW    = operand_fetch_pkg::DW,
  parameter int NREGS = operand_fetch_pkg::NREGS,
  parameter int AW    = operand_fetch_pkg::AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd,
  input  logic [3:0]       in_alu_sel,
  input  logic             in_use_imm,
  input  logic [DW-1:0]    in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    A,
  output logic [DW-1:0]    B,
  output logic [3:0]       ALU_Sel,
  output logic [AW-1:0]    out_rd,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [DW-1:0]    wb_data,
  output logic [NREGS-1:0] busy_regs
);
  import operand_fetch_pkg::*;

  logic [DW-1:0]    rf_a, rf_b;
  logic [DW-1:0]    src_a, src_b;
  logic [NREGS-1:0] busy_reg, busy_next;
  logic             rs1_wait, rs2_wait, rd_wait;
  logic             hazard, accept;
  logic             out_valid_reg;
  logic [DW-1:0]    a_reg, b_reg;
  logic [3:0]       sel_reg;
  logic [AW-1:0]    rd_reg;

  regfile_2r1w #(.DW(DW), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (in_rs1),
    .rdata_a (rf_a),
    .raddr_b (in_rs2),
    .rdata_b (rf_b)
  );

  // Source operands: zero register, then same-cycle write-back, then the file.
  always_comb begin
    src_a = rf_a;
    src_b = rf_b;
    if (in_rs1 == REG_ZERO)                    src_a = '0;
    else if (wb_en && wb_addr == in_rs1)       src_a = wb_data;
    if (in_rs2 == REG_ZERO)                    src_b = '0;
    else if (wb_en && wb_addr == in_rs2)       src_b = wb_data;
  end

  // A busy register stops blocking in the very cycle its write-back arrives.
  assign rs1_wait = (in_rs1 != REG_ZERO) && busy_reg[in_rs1] && !(wb_en && wb_addr == in_rs1);
  assign rs2_wait = (in_rs2 != REG_ZERO) && busy_reg[in_rs2] && !(wb_en && wb_addr == in_rs2);
  assign rd_wait  = (in_rd  != REG_ZERO) && busy_reg[in_rd]  && !(wb_en && wb_addr == in_rd);
  assign hazard   = rs1_wait || (!in_use_imm && rs2_wait) || rd_wait;

  assign in_ready = (!out_valid_reg || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Per-register busy update: a new issue's set overrides a write-back clear.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_track
        assign busy_next[gi] = (accept && in_rd == AW'(gi))   ? 1'b1 :
                               (wb_en  && wb_addr == AW'(gi)) ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  // Output bundle: load on accept, drop when consumed, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sel_reg       <= '0;
      rd_reg        <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      a_reg         <= src_a;
      b_reg         <= in_use_imm ? in_imm : src_b;
      sel_reg       <= in_alu_sel;
      rd_reg        <= in_rd;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign A         = a_reg;
  assign B         = b_reg;
  assign ALU_Sel   = sel_reg;
  assign out_rd    = rd_reg;
  assign busy_regs = busy_reg;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage directly upstream of the ALU. It holds the architectural register file, reads two source registers for each issued op, and optionally substitutes an immediate for operand B.
- Forwards same-cycle write-back data and tracks in-flight destinations with a scoreboard, stalling on RAW/WAW hazards.
- Presents A, B and ALU_Sel to the ALU through a single-entry valid/ready output register. ALU_Out returns via the write-back port.

Parameters:
- DW, 32, data width of registers and operands.
- NREGS, 16, number of architectural registers; register 0 reads as zero and is never written.
- AW, 4, register address width; must equal clog2(NREGS).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  issue request valid.
- in_ready  output  1  stage accepts the issue this cycle.
- in_rs1  input  AW  source register for A.
- in_rs2  input  AW  source register for B.
- in_rd  input  AW  destination register.
- in_alu_sel  input  4  ALU operation code, passed through unchanged.
- in_use_imm  input  1  1: B = in_imm; rs2 ignored for hazards.
- in_imm  input  DW  immediate operand.
- out_valid  output  1  operand bundle valid to ALU.
- out_ready  input  1  downstream consumes the bundle.
- A  output  DW  operand A.
- B  output  DW  operand B.
- ALU_Sel  output  4  registered opcode.
- out_rd  output  AW  registered destination.
- wb_en  input  1  write-back strobe.
- wb_addr  input  AW  write-back register.
- wb_data  input  DW  write-back value (ALU_Out).
- busy_regs  output  NREGS  scoreboard bit per register (debug/verification).

Behaviour:
- Reset (async, rst_n=0): all registers in the file, A, B, out_rd, out_valid, scoreboard and ALU_Sel are cleared to 0. Reset mid-transfer drops the held bundle; no write completes.
- Write-back: on a clk edge with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data and busy[wb_addr] is cleared. Writes to register 0 are ignored.
- Read with bypass (combinational): src(r) = 0 if r==0; wb_data if wb_en && wb_addr==r; otherwise reg[r].
- Hazard stall is asserted when any of the following holds:
  - busy[rs1] && !(wb_en && wb_addr==rs1), with rs1!=0;
  - the same condition for rs2 when in_use_imm=0;
  - busy[rd] && !(wb_en && wb_addr==rd), with rd!=0 (WAW).
- in_ready = (!out_valid || out_ready) && !hazard. in_ready is independent of in_valid.
- Accept: in_valid && in_ready.
  - On accept: A <= src(rs1); B <= in_use_imm ? in_imm : src(rs2); ALU_Sel <= in_alu_sel; out_rd <= in_rd; out_valid <= 1.
  - If in_rd!=0, busy[in_rd] <= 1.
- Latency: accept at edge N, out_valid at N (registered output visible from cycle N+1). Throughput is 1 per cycle when out_ready=1 and there are no hazards.
- Output: out_valid && out_ready with no accept in the same cycle gives out_valid <= 0. A, B, ALU_Sel and out_rd hold stable while out_valid && !out_ready.
- Simultaneous clear and set of the same busy bit (write-back and accept with rd==wb_addr): set wins.
- Simultaneous write-back and read of the same register: the bypassed value is used.
- in_valid=0: registers hold and no scoreboard change occurs.

Decomposition:
- Shared package holds:
  - DW, AW, NREGS;
  - ALU opcode constants OP_ADD=4'b0000 through OP_EQ=4'b1111 (ADD, SUB, AND, OR, XOR, NOT, SLL, SRL, SLA, SRA, MUL, NOR, NAND, XNOR, GT, EQ);
  - REG_ZERO = 0.
- One sub-module, regfile_2r1w: NREGS x DW, two async read ports, one sync write port, r0 hardwired zero, async active-low clear.
- Scoreboard, bypass and output register live in operand_fetch.

Test Plan:
- Reset, then write-back to r3=0x0000_0005 and r4=0x0000_0007; issue rs1=3, rs2=4, rd=5, sel=ADD -> next cycle out_valid=1, A=5, B=7, ALU_Sel=0, out_rd=5, busy_regs[5]=1.
- With busy r5 set, issue rs1=5 -> in_ready=0. Then wb_en, wb_addr=5, wb_data=0xC in the same cycle -> in_ready=1, A=0xC, busy[5] ends cleared.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> A, B, ALU_Sel stable and in_ready=0. Set out_ready=1 with a new issue pending -> back-to-back transfer, no bubble.
- Issue rs1=0, use_imm=1, imm=0xFFFF_FFFF, rd=0 -> A=0, B=0xFFFF_FFFF, busy_regs unchanged. wb to r0 with 0x1234 -> r0 still reads 0.
- WAW: issue rd=6, then issue rd=6 again without write-back -> second stalls. wb r6 plus accept of the second in the same cycle -> busy[6]=1 at the end (set wins).
- Assert rst_n=0 asynchronously mid-cycle while out_valid=1 -> out_valid, A, B and busy_regs go to 0 immediately, without waiting for a clock edge.
